fifo_byte_packer: RTL

Downstream consumer of the byte FIFO's pop interface.
- Accepts 8-bit bytes on a valid/ready handshake and packs LANES consecutive bytes into one word, little-endian lane order.
- Emits each word on a registered valid/ready output together with a lane keep mask and a packet-last flag.
- An in_last byte closes the word early, so a partial word is emitted with a reduced keep mask.
- Feeds the 32-bit bus-side logic.

---
 rtl/fifo_byte_packer_if.sv | 28 ++
 rtl/fifo_byte_packer.sv | 90 +++++++++
 2 files changed

// File: rtl/fifo_byte_packer_if.sv
// Handshake bundle between the byte FIFO pop side, the packer, and the word consumer.
// The packer takes the slave view; the upstream/downstream environment takes the master view.
interface fifo_byte_packer_if #(
  parameter int IN_WIDTH = 8,
  parameter int LANES    = 4,
  parameter int CW       = $clog2(LANES) + 1
);
  logic                      in_valid;
  logic                      in_ready;
  logic [IN_WIDTH-1:0]       in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [IN_WIDTH*LANES-1:0] out_data;
  logic [LANES-1:0]          out_keep;
  logic                      out_last;
  logic [CW-1:0]             count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, count
  );
endinterface

// File: rtl/fifo_byte_packer.sv
// Packs LANES consecutive bytes into one little-endian word with a keep mask and
// packet-last flag; an in_last byte closes the word early.
module fifo_byte_packer #(
  parameter int IN_WIDTH = 8,
  parameter int LANES    = 4,
  parameter int CW       = $clog2(LANES) + 1
) (
  input logic               clk,
  input logic               rst_n,
  fifo_byte_packer_if.slave bus
);

  localparam int OW = IN_WIDTH * LANES;

  logic [OW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic [LANES-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;

  logic             in_ready;
  logic             accept;
  logic             complete;
  logic [OW-1:0]    word;
  logic [LANES-1:0] fill_keep;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign complete = accept && ((count_q == CW'(LANES - 1)) || bus.in_last);

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    word        = acc_q;
    fill_keep   = '0;

    // Unfilled lanes of acc_q are always zero, so the merged word needs no masking.
    for (int k = 0; k < LANES; k++) begin
      if (CW'(k) == count_q) word[k*IN_WIDTH +: IN_WIDTH] = bus.in_data;
      if (CW'(k) <= count_q) fill_keep[k] = 1'b1;
    end

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (complete) begin
        out_valid_d = 1'b1;
        out_data_d  = word;
        out_keep_d  = fill_keep;
        out_last_d  = bus.in_last;
        acc_d       = '0;
        count_d     = '0;
      end else begin
        acc_d   = word;
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
  assign bus.count     = count_q;

endmodule
